fx3_transfer_scheduler: RTL
===========================

Name: fx3_transfer_scheduler

Overview:
- Sequences 16-bit sample transfers from the ADC-side FIFO to the FX3 GPIF in fixed-size bursts, entirely in the fx3_clock domain.
- Decides when data is available to the FX3, times FIFO read requests against the FX3 read handshake, and counts completed bursts.
- Flushes the FIFO when collection stops and raises a sticky buffer error on overflow, underflow or an aborted burst.
- Sits between the sample FIFO and the FX3 control-bus pins (dataAvailable, collectData, readData, bufferError).

Parameters:
- BURST_WORDS, 8192, words per FX3 burst. Power of two, 2..32768.
- FILL_WIDTH, 15, width of the FIFO fill-level input.
- READ_LATENCY, 2, fx3_clock cycles from accepted readData to the first fifo_rdreq. Range 0..15.

Ports:
- fx3_clock  input  1  FX3/FPGA system clock, 60 MHz.
- reset  input  1  asynchronous, active-high reset.
- collectData  input  1  FX3 capture enable, already synchronised to fx3_clock.
- readData  input  1  FX3 is sampling the databus, already synchronised to fx3_clock.
- fifo_usedw  input  FILL_WIDTH  FIFO read-side fill level.
- fifo_empty  input  1  FIFO read-side empty flag.
- fifo_full  input  1  FIFO full flag, fx3_clock domain.
- fifo_rdreq  output  1  FIFO read request; one word per cycle.
- fifo_aclr  output  1  FIFO clear.
- dataAvailable  output  1  at least one burst is buffered and the scheduler is ready.
- isReading  output  1  burst words are being presented to the FX3.
- bufferError  output  1  sticky error flag.
- burstCount  output  16  number of completed bursts.

Behaviour:
- Reset values: fifo_rdreq=0, fifo_aclr=1, dataAvailable=0, isReading=0, bufferError=0, burstCount=0, state=IDLE, all counters 0.
- All outputs are registered.
- States: IDLE, WAIT_FILL, LATENCY, BURST, GAP.
- IDLE:
  - fifo_aclr=1.
  - On collectData=1: go to WAIT_FILL; clear bufferError and burstCount; hold fifo_aclr=1 for that first WAIT_FILL cycle, then 0.
- collectData=0 in any non-IDLE state: next state is IDLE; fifo_rdreq, isReading and dataAvailable go to 0 on that same edge. bufferError holds its value until the next collectData rise.
- WAIT_FILL:
  - dataAvailable = registered (fifo_usedw >= BURST_WORDS), i.e. one cycle behind fifo_usedw.
  - readData=1 while dataAvailable=1: load the latency counter with READ_LATENCY, set dataAvailable=0, go to LATENCY. If READ_LATENCY=0, go directly to BURST.
  - readData=1 while dataAvailable=0: set bufferError (underrun request); stay in WAIT_FILL.
- LATENCY:
  - Decrement the counter each cycle; on reaching 0, go to BURST.
  - readData=0 during LATENCY: set bufferError; go to GAP.
- BURST:
  - fifo_rdreq=1 and isReading=1 every cycle; the word counter increments per cycle.
  - After exactly BURST_WORDS rdreq cycles: deassert both outputs, burstCount += 1 (wraps 0xFFFF->0), go to GAP.
  - fifo_rdreq=1 with fifo_empty=1: set bufferError (underflow); the burst continues to full length.
  - readData=0 mid-burst: set bufferError; deassert rdreq/isReading next cycle; go to GAP; burstCount is not incremented.
- GAP: wait for readData=0, then go to WAIT_FILL. dataAvailable may reassert no earlier than the cycle after GAP exits.
- fifo_full=1 in WAIT_FILL, LATENCY, BURST or GAP sets bufferError (overflow, data lost upstream).
- bufferError is sticky: it is cleared only by reset or a collectData rise. Simultaneous error sources set it once. A burst completing in the same cycle as an error still increments burstCount.
- Reset asserted mid-burst: all outputs take their reset values asynchronously; fifo_aclr=1 immediately.
- Throughput: with BURST_WORDS=8192 and READ_LATENCY=2, a burst occupies exactly 8194 cycles from the readData-accept edge to the last rdreq.

Test Plan:
- Reset, then collectData=1 with fifo_usedw=8191 -> dataAvailable stays 0. Set fifo_usedw=8192 -> dataAvailable=1 one cycle later. fifo_aclr=1 for exactly one cycle after the collectData rise.
- readData=1 with dataAvailable=1, READ_LATENCY=2 -> dataAvailable=0 next edge. fifo_rdreq is high for exactly 8192 consecutive cycles starting 2 cycles after accept. burstCount=1. bufferError=0.
- readData dropped after 100 burst words -> fifo_rdreq=0 next cycle, bufferError=1, burstCount unchanged, state GAP then WAIT_FILL.
- fifo_empty pulsed mid-burst; separately, fifo_full pulsed in WAIT_FILL -> bufferError=1 and held. Toggle collectData 1->0->1 -> bufferError=0, burstCount=0, FIFO flushed.
- Force burstCount to 65535, then complete a burst -> burstCount=0. Assert readData while dataAvailable=0 -> bufferError=1, no rdreq issued.
- collectData=0 mid-burst, and separately reset asserted mid-burst -> rdreq/isReading low immediately (reset) or next edge (collectData); fifo_aclr=1; state IDLE.

Source files
------------

// File: rtl/fx3_transfer_scheduler.sv
// Schedules fixed-size FIFO-to-FX3 bursts: announces buffered data, paces FIFO reads
// against the FX3 read handshake, counts completed bursts and flags buffer errors.
module fx3_transfer_scheduler #(
    parameter int BURST_WORDS  = 8192,
    parameter int FILL_WIDTH   = 15,
    parameter int READ_LATENCY = 2
) (
    input  logic                  fx3_clock,
    input  logic                  reset,
    input  logic                  collectData,
    input  logic                  readData,
    input  logic [FILL_WIDTH-1:0] fifo_usedw,
    input  logic                  fifo_empty,
    input  logic                  fifo_full,
    output logic                  fifo_rdreq,
    output logic                  fifo_aclr,
    output logic                  dataAvailable,
    output logic                  isReading,
    output logic                  bufferError,
    output logic [15:0]           burstCount
);

    localparam int WORD_W = (BURST_WORDS > 2) ? $clog2(BURST_WORDS) : 1;
    localparam logic [WORD_W-1:0]   LAST_WORD = WORD_W'(BURST_WORDS - 1);
    // One extra bit so a burst size equal to 2**FILL_WIDTH still compares correctly.
    localparam logic [FILL_WIDTH:0] BURST_LVL = (FILL_WIDTH + 1)'(BURST_WORDS);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_FILL = 3'd1,
        LATENCY   = 3'd2,
        BURST     = 3'd3,
        GAP       = 3'd4
    } state_t;

    state_t              state_reg;
    logic [WORD_W-1:0]   word_cnt_reg;
    logic [3:0]          lat_cnt_reg;
    logic                rdreq_reg;
    logic                aclr_reg;
    logic                avail_reg;
    logic                reading_reg;
    logic                error_reg;
    logic [15:0]         burst_count_reg;
    logic                err_set;
    logic                fill_ok;

    assign fill_ok = ({1'b0, fifo_usedw} >= BURST_LVL);

    // Any error source seen while collecting; several at once still just set the flag.
    always_comb begin
        err_set = 1'b0;
        if (collectData && state_reg != IDLE) begin
            if (fifo_full)
                err_set = 1'b1;
            if (rdreq_reg && fifo_empty)
                err_set = 1'b1;
            if (state_reg == WAIT_FILL && readData && !avail_reg)
                err_set = 1'b1;
            if ((state_reg == LATENCY || state_reg == BURST) && !readData)
                err_set = 1'b1;
        end
    end

    always_ff @(posedge fx3_clock or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            word_cnt_reg    <= '0;
            lat_cnt_reg     <= '0;
            rdreq_reg       <= 1'b0;
            aclr_reg        <= 1'b1;
            avail_reg       <= 1'b0;
            reading_reg     <= 1'b0;
            error_reg       <= 1'b0;
            burst_count_reg <= '0;
        end else begin
            if (err_set)
                error_reg <= 1'b1;

            if (state_reg != IDLE && !collectData) begin
                state_reg   <= IDLE;
                rdreq_reg   <= 1'b0;
                reading_reg <= 1'b0;
                avail_reg   <= 1'b0;
                aclr_reg    <= 1'b1;
            end else begin
                case (state_reg)
                    IDLE: begin
                        aclr_reg    <= 1'b1;
                        rdreq_reg   <= 1'b0;
                        reading_reg <= 1'b0;
                        avail_reg   <= 1'b0;
                        if (collectData) begin
                            state_reg       <= WAIT_FILL;
                            error_reg       <= 1'b0;
                            burst_count_reg <= '0;
                        end
                    end
                    WAIT_FILL: begin
                        aclr_reg <= 1'b0;
                        if (readData && avail_reg) begin
                            avail_reg    <= 1'b0;
                            word_cnt_reg <= '0;
                            if (READ_LATENCY == 0) begin
                                state_reg   <= BURST;
                                rdreq_reg   <= 1'b1;
                                reading_reg <= 1'b1;
                            end else begin
                                lat_cnt_reg <= 4'(READ_LATENCY);
                                state_reg   <= LATENCY;
                            end
                        end else begin
                            avail_reg <= fill_ok;
                        end
                    end
                    LATENCY: begin
                        if (!readData) begin
                            state_reg <= GAP;
                        end else begin
                            lat_cnt_reg <= lat_cnt_reg - 4'd1;
                            // Counter hits zero on this edge, so the first read is issued now.
                            if (lat_cnt_reg == 4'd1) begin
                                state_reg   <= BURST;
                                rdreq_reg   <= 1'b1;
                                reading_reg <= 1'b1;
                            end
                        end
                    end
                    BURST: begin
                        if (!readData) begin
                            rdreq_reg   <= 1'b0;
                            reading_reg <= 1'b0;
                            state_reg   <= GAP;
                        end else begin
                            word_cnt_reg <= word_cnt_reg + 1'b1;
                            if (word_cnt_reg == LAST_WORD) begin
                                rdreq_reg       <= 1'b0;
                                reading_reg     <= 1'b0;
                                burst_count_reg <= burst_count_reg + 16'd1;
                                state_reg       <= GAP;
                            end
                        end
                    end
                    GAP: begin
                        if (!readData)
                            state_reg <= WAIT_FILL;
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign fifo_rdreq    = rdreq_reg;
    assign fifo_aclr     = aclr_reg;
    assign dataAvailable = avail_reg;
    assign isReading     = reading_reg;
    assign bufferError   = error_reg;
    assign burstCount    = burst_count_reg;

endmodule
